// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Walks a song held in an external note ROM and drives the sine generator.
// Each ROM entry is {frequency[13:0], duration[7:0]}. Pitch changes are
// deferred to the generator's phase-zero point (bounded by ZERO_TIMEOUT) so the
// waveform never jumps mid-cycle. Rests (frequency 0) apply at once. The
// all-zero entry marks the end of the song.
//
// Optional build macro: NOTE_SEQUENCER_ENVELOPE_EN
//   defined   -> linear attack/release envelope on genAmplitude
//   undefined -> flat MAX_AMPLITUDE for every sounding PLAY cycle
//
// Ports:
//   CLK_32KHz    audio clock
//   reset_n      asynchronous active-low reset
//   start        one-cycle pulse, begin the song at address 0 (ignored if busy)
//   stop         one-cycle pulse, abort immediately (beats start)
//   loopEnable   restart at address 0 when the end marker is reached
//   romAddress   registered ROM address
//   romData      {freq[21:8], dur[7:0]}, valid one cycle after romAddress
//   genIndexZero generator phase-zero flag
//   genFrequency generator frequency (Hz)
//   genAmplitude generator amplitude
//   busy         high from start until song end or stop
//   noteStrobe   one-cycle pulse on the first cycle a new note is applied
//   songDone     one-cycle pulse when the end marker is reached
// -----------------------------------------------------------------------------
module note_sequencer #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned TICK_DIV      = 32,
  parameter int unsigned MAX_AMPLITUDE = 255,
  parameter int unsigned ATTACK_STEP   = 8,
  parameter int unsigned ZERO_TIMEOUT  = 255
) (
  input  logic              CLK_32KHz,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loopEnable,
  output logic [ADDR_W-1:0] romAddress,
  input  logic [21:0]       romData,
  input  logic              genIndexZero,
  output logic [13:0]       genFrequency,
  output logic [7:0]        genAmplitude,
  output logic              busy,
  output logic              noteStrobe,
  output logic              songDone
);

  // Duration counter holds up to 255 * TICK_DIV - 1 without overflow.
  localparam int unsigned CNT_W = 8 + $clog2(TICK_DIV);

`ifdef NOTE_SEQUENCER_ENVELOPE_EN
  localparam bit ENV_ON = 1'b1;
`else
  localparam bit ENV_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_ZERO,
    S_PLAY
  } state_e;

  // Amplitude for play cycle k of a note whose last cycle index is last
  // (N = last + 1): min(MAX, STEP*(k+1), STEP*(N-k)) with the envelope on.
  function automatic logic [7:0] amp_at(input logic [CNT_W-1:0] k,
                                        input logic [CNT_W-1:0] last);
    int unsigned amp;
    int unsigned rise;
    int unsigned fall;
    amp  = MAX_AMPLITUDE;
    rise = ATTACK_STEP * (32'(k) + 32'd1);
    fall = ATTACK_STEP * (32'(last) - 32'(k) + 32'd1);
    if (ENV_ON) begin
      if (rise < amp) amp = rise;
      if (fall < amp) amp = fall;
    end
    return amp[7:0];
  endfunction

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [13:0]       note_freq_q, note_freq_d;
  logic [CNT_W-1:0]  last_q,      last_d;
  logic              rest_q,      rest_d;
  logic [CNT_W-1:0]  k_q,         k_d;
  logic [7:0]        zcnt_q,      zcnt_d;
  logic [13:0]       freq_q,      freq_d;
  logic [7:0]        amp_q,       amp_d;
  logic              busy_q,      busy_d;
  logic              strobe_q,    strobe_d;
  logic              done_q,      done_d;

  logic [13:0]       rom_freq;
  logic [7:0]        rom_dur;
  logic [7:0]        dur_eff;

  assign rom_freq = romData[21:8];
  assign rom_dur  = romData[7:0];
  // A zero duration on a real note plays as one unit.
  assign dur_eff  = (rom_dur == 8'd0) ? 8'd1 : rom_dur;

  // NOTE: every *_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    note_freq_d = note_freq_q;
    last_d      = last_q;
    rest_d      = rest_q;
    k_d         = k_q;
    zcnt_d      = zcnt_q;
    freq_d      = freq_q;
    amp_d       = amp_q;
    busy_d      = busy_q;
    strobe_d    = 1'b0;
    done_d      = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      freq_d  = '0;
      amp_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          freq_d = '0;
          amp_d  = '0;
          if (start) begin
            addr_d  = '0;
            busy_d  = 1'b1;
            state_d = S_FETCH;
          end
        end

        S_FETCH: state_d = S_LOAD;

        S_LOAD: begin
          if (rom_freq == 14'd0 && rom_dur == 8'd0) begin
            done_d = 1'b1;
            if (loopEnable) begin
              addr_d  = '0;
              state_d = S_FETCH;
            end else begin
              busy_d  = 1'b0;
              freq_d  = '0;
              state_d = S_IDLE;
            end
          end else begin
            note_freq_d = rom_freq;
            last_d      = CNT_W'(dur_eff) * CNT_W'(TICK_DIV) - CNT_W'(1);
            rest_d      = (rom_freq == 14'd0);
            zcnt_d      = '0;
            if (rom_freq == 14'd0) begin
              // Rests skip the phase-zero wait: silence cannot click.
              freq_d   = '0;
              strobe_d = 1'b1;
              k_d      = '0;
              amp_d    = '0;
              state_d  = S_PLAY;
            end else begin
              state_d = S_WAIT_ZERO;
            end
          end
        end

        S_WAIT_ZERO: begin
          if (genIndexZero || zcnt_q == 8'(ZERO_TIMEOUT - 1)) begin
            freq_d   = note_freq_q;
            strobe_d = 1'b1;
            k_d      = '0;
            amp_d    = rest_q ? 8'd0 : amp_at('0, last_q);
            state_d  = S_PLAY;
          end else begin
            zcnt_d = zcnt_q + 8'd1;
          end
        end

        S_PLAY: begin
          if (k_q == last_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            amp_d   = '0;
            state_d = S_FETCH;
          end else begin
            k_d   = k_q + CNT_W'(1);
            amp_d = rest_q ? 8'd0 : amp_at(k_q + CNT_W'(1), last_q);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      note_freq_q <= '0;
      last_q      <= '0;
      rest_q      <= 1'b0;
      k_q         <= '0;
      zcnt_q      <= '0;
      freq_q      <= '0;
      amp_q       <= '0;
      busy_q      <= 1'b0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      note_freq_q <= note_freq_d;
      last_q      <= last_d;
      rest_q      <= rest_d;
      k_q         <= k_d;
      zcnt_q      <= zcnt_d;
      freq_q      <= freq_d;
      amp_q       <= amp_d;
      busy_q      <= busy_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
    end
  end

  assign romAddress   = addr_q;
  assign genFrequency = freq_q;
  assign genAmplitude = amp_q;
  assign busy         = busy_q;
  assign noteStrobe   = strobe_q;
  assign songDone     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//
// Self-checking bench for note_sequencer. Expected note frequencies are pushed
// to a scoreboard queue when a song is loaded and popped on each noteStrobe.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        gen_zero = 1'b1;
  logic [7:0]  rom_addr;
  logic [21:0] rom_data = '0;
  logic [13:0] gen_freq;
  logic [7:0]  gen_amp;
  logic        busy;
  logic        strobe;
  logic        done;

  logic [21:0] rom [256];
  logic [13:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Synchronous song ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  note_sequencer dut (
    .CLK_32KHz    (clk),
    .reset_n      (rst_n),
    .start        (start),
    .stop         (stop),
    .loopEnable   (loop_en),
    .romAddress   (rom_addr),
    .romData      (rom_data),
    .genIndexZero (gen_zero),
    .genFrequency (gen_freq),
    .genAmplitude (gen_amp),
    .busy         (busy),
    .noteStrobe   (strobe),
    .songDone     (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = '0;
  endtask

  task automatic set_rom(input int idx, input int f, input int d);
    logic [13:0] fv;
    logic [7:0]  dv;
    fv = 14'(f);
    dv = 8'(d);
    rom[idx] = {fv, dv};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Scoreboard consumer: wait (bounded) for the next noteStrobe, then compare
  // genFrequency against the oldest expected note.
  task automatic sb_note(input string name, output int cycles);
    logic [13:0] exp_f;
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (strobe !== 1'b1 && cycles < 400);
    total++;
    if (strobe !== 1'b1) begin
      bad++;
      $display("FAIL %s_strobe: noteStrobe=%b after %0d cycles, required 1", name, strobe, cycles);
    end else if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: unexpected note genFrequency=%0d, queue empty", name, gen_freq);
    end else begin
      exp_f = exp_q.pop_front();
      total++;
      if (gen_freq !== exp_f) begin
        bad++;
        $display("FAIL %s_freq: genFrequency=%0d required %0d", name, gen_freq, exp_f);
      end
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (done !== 1'b1 && cycles < 600);
  endtask

  function automatic int model_amp(input int k, input int n);
    int a;
    a = 255;
`ifdef NOTE_SEQUENCER_ENVELOPE_EN
    if (8 * (k + 1) < a) a = 8 * (k + 1);
    if (8 * (n - k) < a) a = 8 * (n - k);
`endif
    return a;
  endfunction

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    tick(2);
    total++;
    if ({rom_addr, gen_freq, gen_amp, busy, strobe, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: addr=%0d freq=%0d amp=%0d busy=%b strobe=%b done=%b required all 0",
               rom_addr, gen_freq, gen_amp, busy, strobe, done);
    end
    rst_n = 1'b1;
    tick(1);
    // Reset in the middle of the second note.
    clear_rom();
    set_rom(0, 440, 1);
    set_rom(1, 440, 20);
    exp_q.push_back(14'd440);
    exp_q.push_back(14'd440);
    pulse_start();
    sb_note("reset_n1", cyc);
    sb_note("reset_n2", cyc);
    tick(5);
    total++;
    if (rom_addr !== 8'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_preplay: addr=%0d busy=%b required 1/1", rom_addr, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rom_addr, gen_freq, gen_amp, busy, strobe, done} !== '0) begin
      bad++;
      $display("FAIL reset_async: addr=%0d freq=%0d amp=%0d busy=%b required all 0",
               rom_addr, gen_freq, gen_amp, busy);
    end
    tick(1);
    rst_n = 1'b1;
    tick(5);
    total++;
    if ({rom_addr, gen_freq, gen_amp, busy, strobe, done} !== '0) begin
      bad++;
      $display("FAIL reset_idle: addr=%0d freq=%0d amp=%0d busy=%b required all 0",
               rom_addr, gen_freq, gen_amp, busy);
    end
  endtask

  task automatic test_single_note();
    int cyc;
    int n;
    clear_rom();
    set_rom(0, 440, 2);
    gen_zero = 1'b1;
    exp_q.push_back(14'd440);
    pulse_start();
    sb_note("single", cyc);
    total++;
    if (cyc !== 3) begin
      bad++;
      $display("FAIL single_latency: start-to-strobe=%0d required 3", cyc);
    end
    n = 0;
    while (gen_amp !== 8'd0 && n < 1000) begin
      n++;
      tick(1);
    end
    total++;
    if (n !== 64) begin
      bad++;
      $display("FAIL single_len: sounding cycles=%0d required 64", n);
    end
    total++;
    if (rom_addr !== 8'd1) begin
      bad++;
      $display("FAIL single_addr: romAddress=%0d required 1", rom_addr);
    end
    tick(1);
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_load: songDone=%b busy=%b required 0/1", done, busy);
    end
    tick(1);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || gen_freq !== 14'd0) begin
      bad++;
      $display("FAIL single_end: songDone=%b busy=%b freq=%0d required 1/0/0", done, busy, gen_freq);
    end
    tick(1);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL single_done_pulse: songDone=%b required 0", done);
    end
  endtask

  task automatic test_zero_sync();
    int cyc;
    int nz;
    logic [13:0] exp_f;
    clear_rom();
    set_rom(0, 700, 1);
    gen_zero = 1'b0;
    exp_q.push_back(14'd700);
    pulse_start();          // FETCH
    tick(2);                // WAIT_ZERO cycle 0
    tick(10);               // WAIT_ZERO cycle 10
    gen_zero = 1'b1;
    total++;
    if (gen_freq !== 14'd0 || strobe !== 1'b0) begin
      bad++;
      $display("FAIL zero_hold: freq=%0d strobe=%b required 0/0", gen_freq, strobe);
    end
    tick(1);
    gen_zero = 1'b0;
    exp_f = exp_q.pop_front();
    total++;
    if (strobe !== 1'b1 || gen_freq !== exp_f) begin
      bad++;
      $display("FAIL zero_pulse: strobe=%b freq=%0d required 1/%0d", strobe, gen_freq, exp_f);
    end
    wait_done(cyc);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL zero_done: songDone=%b required 1", done);
    end
    // Forced change after the timeout, then a rest that does not wait.
    clear_rom();
    set_rom(0, 900, 1);
    set_rom(1, 0, 3);
    exp_q.push_back(14'd900);
    exp_q.push_back(14'd0);
    tick(2);
    pulse_start();
    sb_note("timeout", cyc);
    total++;
    if (cyc !== 257) begin
      bad++;
      $display("FAIL timeout_len: start-to-strobe=%0d required 257", cyc);
    end
    sb_note("rest", cyc);
    total++;
    if (cyc !== 34) begin
      bad++;
      $display("FAIL rest_nowait: note-to-rest strobe=%0d required 34", cyc);
    end
    nz = 0;
    for (int i = 0; i < 96; i++) begin
      if (gen_amp !== 8'd0) nz++;
      if (i == 95) begin
        total++;
        if (rom_addr !== 8'd1) begin
          bad++;
          $display("FAIL rest_last: romAddress=%0d at k=95 required 1", rom_addr);
        end
      end
      tick(1);
    end
    total++;
    if (nz !== 0 || rom_addr !== 8'd2) begin
      bad++;
      $display("FAIL rest_len: nonzero amp cycles=%0d addr=%0d required 0/2", nz, rom_addr);
    end
    wait_done(cyc);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rest_end: songDone=%b busy=%b required 1/0", done, busy);
    end
    gen_zero = 1'b1;
  endtask

  task automatic test_envelope();
    int cyc;
    int mism;
    logic [7:0] amps [64];
    int e0;
    int e31;
    int e63;
`ifdef NOTE_SEQUENCER_ENVELOPE_EN
    e0 = 8; e31 = 255; e63 = 8;
`else
    e0 = 255; e31 = 255; e63 = 255;
`endif
    clear_rom();
    set_rom(0, 1000, 2);
    exp_q.push_back(14'd1000);
    tick(2);
    pulse_start();
    sb_note("env", cyc);
    for (int k = 0; k < 64; k++) begin
      amps[k] = gen_amp;
      tick(1);
    end
    total++;
    if (32'(amps[0]) !== e0 || 32'(amps[31]) !== e31 || 32'(amps[63]) !== e63) begin
      bad++;
      $display("FAIL env_points: k0=%0d k31=%0d k63=%0d required %0d/%0d/%0d",
               amps[0], amps[31], amps[63], e0, e31, e63);
    end
    mism = 0;
    for (int k = 0; k < 64; k++) if (32'(amps[k]) !== model_amp(k, 64)) mism++;
    total++;
    if (mism !== 0 || gen_amp !== 8'd0) begin
      bad++;
      $display("FAIL env_shape: mismatching cycles=%0d amp after=%0d required 0/0", mism, gen_amp);
    end
    wait_done(cyc);
  endtask

  task automatic test_stop();
    int cyc;
    int bad_cycles;
    clear_rom();
    set_rom(0, 440, 10);
    exp_q.push_back(14'd440);
    tick(2);
    pulse_start();
    sb_note("stop", cyc);
    tick(20);               // k = 20
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    total++;
    if (gen_amp !== 8'd0 || gen_freq !== 14'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL stop_now: amp=%0d freq=%0d busy=%b done=%b required 0/0/0/0",
               gen_amp, gen_freq, busy, done);
    end
    bad_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (done !== 1'b0 || busy !== 1'b0 || gen_amp !== 8'd0) bad_cycles++;
    end
    total++;
    if (bad_cycles !== 0) begin
      bad++;
      $display("FAIL stop_quiet: active cycles after stop=%0d required 0", bad_cycles);
    end
  endtask

  task automatic test_collision();
    int act;
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0 || strobe !== 1'b0) act++;
      tick(1);
    end
    total++;
    if (act !== 0) begin
      bad++;
      $display("FAIL start_stop: active cycles=%0d required 0", act);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int n;
    int extra;
    clear_rom();
    set_rom(0, 440, 3);
    exp_q.push_back(14'd440);
    pulse_start();
    sb_note("busy_start", cyc);
    tick(10);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 11;
    extra = 0;
    while (done !== 1'b1 && n < 600) begin
      tick(1);
      n++;
      if (strobe === 1'b1) extra++;
    end
    total++;
    if (n !== 98 || extra !== 0) begin
      bad++;
      $display("FAIL busy_start: strobe-to-done=%0d extra strobes=%0d required 98/0", n, extra);
    end
  endtask

  task automatic test_loop();
    int cyc;
    int n;
    bit seen2;
    int drops;
    clear_rom();
    set_rom(0, 500, 1);
    set_rom(1, 600, 1);
    loop_en = 1'b1;
    repeat (2) begin
      exp_q.push_back(14'd500);
      exp_q.push_back(14'd600);
    end
    tick(2);
    pulse_start();
    sb_note("loop1a", cyc);
    total++;
    if (rom_addr !== 8'd0) begin
      bad++;
      $display("FAIL loop1a_addr: romAddress=%0d required 0", rom_addr);
    end
    sb_note("loop1b", cyc);
    total++;
    if (rom_addr !== 8'd1) begin
      bad++;
      $display("FAIL loop1b_addr: romAddress=%0d required 1", rom_addr);
    end
    n = 0;
    seen2 = 1'b0;
    drops = 0;
    do begin
      tick(1);
      n++;
      if (rom_addr === 8'd2) seen2 = 1'b1;
      if (busy !== 1'b1) drops++;
    end while (done !== 1'b1 && n < 400);
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || rom_addr !== 8'd0 || !seen2 || drops !== 0) begin
      bad++;
      $display("FAIL loop_wrap: done=%b busy=%b addr=%0d seen2=%b busy drops=%0d required 1/1/0/1/0",
               done, busy, rom_addr, seen2, drops);
    end
    tick(1);
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL loop_pulse: songDone=%b busy=%b required 0/1", done, busy);
    end
    sb_note("loop2a", cyc);
    loop_en = 1'b0;
    sb_note("loop2b", cyc);
    wait_done(cyc);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || gen_freq !== 14'd0) begin
      bad++;
      $display("FAIL loop_end: songDone=%b busy=%b freq=%0d required 1/0/0", done, busy, gen_freq);
    end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_zero_sync();
    test_envelope();
    test_stop();
    test_collision();
    test_back_to_back();
    test_loop();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expected notes never played, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
